// File: rtl/requant_stage.sv
// requant_stage: 32-bit accumulator to OUT_W-bit activation requantizer, 4-stage valid/ready pipeline.
// Define REQUANT_RELU_EN to raise the lower clamp bound to the output zero point (fused ReLU).
module requant_stage #(
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_acc,
    input  logic [31:0]        in_bias,
    input  logic [31:0]        cfg_mult,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic [OUT_W-1:0]   cfg_zp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_sat,
    output logic               busy
);

    localparam logic signed [33:0] C_HI = (34'sd1 <<< (OUT_W - 1)) - 34'sd1;
    localparam logic signed [33:0] C_LO = -(34'sd1 <<< (OUT_W - 1));

    // Returns {clipped, value}: 33-bit sum saturated back into 32-bit signed range.
    function automatic logic [32:0] add_sat32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {a[31], a} + {b[31], b};
        if (sum[32] != sum[31]) begin
            add_sat32 = {1'b1, (sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
        end else begin
            add_sat32 = {1'b0, sum[31:0]};
        end
    endfunction

    logic                     r_v1, r_v2, r_v3, r_v4;
    logic signed [31:0]       r_s1;
    logic                     r_sat1;
    logic signed [63:0]       r_p;
    logic                     r_min2, r_sat2;
    logic signed [31:0]       r_h;
    logic                     r_sat3;
    logic [OUT_W-1:0]         r_out;
    logic                     r_sat4;

    logic                     w_adv;
    logic [32:0]              w_s1_sat;
    logic signed [63:0]       w_t, w_q;
    logic signed [31:0]       w_h;
    logic                     w_h_sat;
    logic [31:0]              w_mask, w_rem, w_thr;
    logic signed [32:0]       w_r;
    logic signed [33:0]       w_zp, w_y, w_lo;
    logic [OUT_W-1:0]         w_out;
    logic                     w_clip;
    logic                     w_unused_q;

    assign w_adv      = !r_v4 || out_ready;
    assign in_ready   = w_adv;
    assign w_s1_sat   = add_sat32(in_acc, in_bias);
    assign w_unused_q = ^w_q[63:32];

    // Rounding doubling high multiply; the quotient by 2^31 truncates toward zero.
    always_comb begin
        w_t = r_p + (r_p[63] ? 64'shFFFF_FFFF_C000_0001 : 64'sh0000_0000_4000_0000);
        if (w_t[63]) begin
            w_q = (w_t + 64'sh0000_0000_7FFF_FFFF) >>> 31;
        end else begin
            w_q = w_t >>> 31;
        end
        if (r_min2) begin
            w_h     = 32'sh7FFF_FFFF;
            w_h_sat = 1'b1;
        end else begin
            w_h     = w_q[31:0];
            w_h_sat = r_sat2;
        end
    end

    // Rounding right shift (half away from zero), zero-point add and final clamp.
    always_comb begin
        w_mask = (32'd1 << cfg_shift) - 32'd1;
        w_rem  = r_h & w_mask;
        w_thr  = (w_mask >> 1) + {31'd0, r_h[31]};
        w_r    = ($signed({r_h[31], r_h}) >>> cfg_shift) + $signed({32'd0, (w_rem > w_thr)});
        w_zp   = $signed({{(34 - OUT_W){cfg_zp[OUT_W-1]}}, cfg_zp});
        w_y    = $signed({w_r[32], w_r}) + w_zp;
`ifdef REQUANT_RELU_EN
        w_lo   = (w_zp > C_LO) ? w_zp : C_LO;
`else
        w_lo   = C_LO;
`endif
        w_out  = w_y[OUT_W-1:0];
        w_clip = 1'b0;
        if (w_y > C_HI) begin
            w_out  = C_HI[OUT_W-1:0];
            w_clip = 1'b1;
        end else if (w_y < w_lo) begin
            w_out  = w_lo[OUT_W-1:0];
            w_clip = 1'b1;
        end else begin
            w_out  = w_y[OUT_W-1:0];
            w_clip = 1'b0;
        end
    end

    // Pipeline registers: every stage moves together whenever the output slot can advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_v4   <= 1'b0;
            r_s1   <= 32'sd0;
            r_sat1 <= 1'b0;
            r_p    <= 64'sd0;
            r_min2 <= 1'b0;
            r_sat2 <= 1'b0;
            r_h    <= 32'sd0;
            r_sat3 <= 1'b0;
            r_out  <= '0;
            r_sat4 <= 1'b0;
        end else if (w_adv) begin
            r_v1   <= in_valid;
            r_s1   <= w_s1_sat[31:0];
            r_sat1 <= w_s1_sat[32];
            r_v2   <= r_v1;
            r_p    <= $signed({{32{r_s1[31]}}, r_s1}) * $signed({{32{cfg_mult[31]}}, cfg_mult});
            r_min2 <= (r_s1 == 32'sh8000_0000) && (cfg_mult == 32'h8000_0000);
            r_sat2 <= r_sat1;
            r_v3   <= r_v2;
            r_h    <= w_h;
            r_sat3 <= w_h_sat;
            r_v4   <= r_v3;
            r_out  <= w_out;
            r_sat4 <= r_sat3 | w_clip;
        end
    end

    assign out_valid = r_v4;
    assign out_data  = r_out;
    assign out_sat   = r_sat4;
    assign busy      = r_v1 | r_v2 | r_v3 | r_v4;

endmodule
